// File: rtl/cpu_pkg.sv
// Shared constants and types for the accumulator CPU control path.
// Opcodes, ALU codes, FSM states and datapath mux encodings.
package cpu_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_LOAD    = 4'h1;
  localparam logic [3:0] OP_STORE   = 4'h2;
  localparam logic [3:0] OP_ADD     = 4'h3;
  localparam logic [3:0] OP_SUB     = 4'h4;
  localparam logic [3:0] OP_AND     = 4'h5;
  localparam logic [3:0] OP_OR      = 4'h6;
  localparam logic [3:0] OP_XOR     = 4'h7;
  localparam logic [3:0] OP_SHL     = 4'h8;
  localparam logic [3:0] OP_SHR     = 4'h9;
  localparam logic [3:0] OP_JUMP    = 4'hA;
  localparam logic [3:0] OP_SKIPZ   = 4'hB;
  localparam logic [3:0] OP_SKIPNEG = 4'hC;
  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SHL = 4'b0100;
  localparam logic [3:0] ALU_SHR = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;

  localparam logic PC_SEL_INC  = 1'b0;
  localparam logic PC_SEL_IR   = 1'b1;
  localparam logic MAR_SEL_PC  = 1'b0;
  localparam logic MAR_SEL_IR  = 1'b1;
  localparam logic ACC_SEL_ALU = 1'b0;
  localparam logic ACC_SEL_MBR = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_F_MAR  = 4'd1,
    S_F_WAIT = 4'd2,
    S_F_IR   = 4'd3,
    S_DECODE = 4'd4,
    S_E_MAR  = 4'd5,
    S_E_WAIT = 4'd6,
    S_E_MBR  = 4'd7,
    S_E_EXEC = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  // Opcodes that complete in DECODE without touching memory.
  function automatic logic retires_in_decode(input logic [3:0] op);
    return op inside {OP_NOP, OP_SHL, OP_SHR, OP_JUMP,
                      OP_SKIPZ, OP_SKIPNEG, OP_HALT};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable 3-bit down-counter timing memory access latency.
// done is high once the count has reached zero.
module mem_wait_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] value,
  output logic       done
);

  logic [2:0] count;

  // Load on wait-state entry, then count down to zero and hold.
  always_ff @(posedge clk) begin
    if (reset)
      count <= 3'd0;
    else if (load)
      count <= value;
    else if (count != 3'd0)
      count <= count - 3'd1;
  end

  assign done = (count == 3'd0);

endmodule

// File: rtl/accumulator_control_unit.sv
// Multi-cycle Moore control FSM for the accumulator CPU datapath.
// Sequences fetch/decode/execute, tracks halt, illegal, retire count.
module accumulator_control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] acc,
  output logic              pc_write,
  output logic              pc_sel,
  output logic              mar_write,
  output logic              mar_sel,
  output logic              mbr_write,
  output logic              ir_write,
  output logic              acc_write,
  output logic              acc_sel,
  output logic              mem_write,
  output logic [3:0]        alu_op,
  output logic              halted,
  output logic              illegal,
  output logic [3:0]        state,
  output logic [15:0]       instr_retired
);

  state_t     st;
  logic [3:0] op;
  logic       skip;
  logic       retire;
  logic       timer_load;
  logic       timer_done;
  logic       unused_addr;

  assign op     = ir[DATA_W-1 -: 4];
  assign state  = st;
  assign halted = (st == S_HALT);

  // The address field feeds the datapath muxes, not this FSM.
  assign unused_addr = ^ir[ADDR_W-1:0];

  assign skip = (op == OP_SKIPZ && acc == '0) ||
                (op == OP_SKIPNEG && acc[DATA_W-1]);

  assign retire = (st == S_E_EXEC) ||
                  (st == S_DECODE && retires_in_decode(op));

  // Both wait states are entered from the cycle after a MAR load.
  assign timer_load = (st == S_F_MAR) || (st == S_E_MAR);

  mem_wait_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .value (3'(MEM_LATENCY - 1)),
    .done  (timer_done)
  );

  // State sequencing, sticky illegal flag and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= S_IDLE;
      illegal       <= 1'b0;
      instr_retired <= 16'd0;
    end else begin
      if (retire)
        instr_retired <= instr_retired + 16'd1;
      unique case (st)
        S_IDLE:   if (start) st <= S_F_MAR;
        S_F_MAR:  st <= S_F_WAIT;
        S_F_WAIT: if (timer_done) st <= S_F_IR;
        S_F_IR:   st <= S_DECODE;
        S_DECODE: begin
          unique case (op)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_XOR: st <= S_E_MAR;
            OP_NOP, OP_SHL, OP_SHR, OP_JUMP,
            OP_SKIPZ, OP_SKIPNEG:  st <= S_F_MAR;
            OP_HALT:               st <= S_HALT;
            default: begin
              illegal <= 1'b1;
              st      <= S_HALT;
            end
          endcase
        end
        S_E_MAR:  st <= (op == OP_STORE) ? S_E_EXEC : S_E_WAIT;
        S_E_WAIT: if (timer_done) st <= S_E_MBR;
        S_E_MBR:  st <= S_E_EXEC;
        S_E_EXEC: st <= S_F_MAR;
        S_HALT:   st <= S_HALT;
        default:  st <= S_IDLE;
      endcase
    end
  end

  // Moore decode of strobes and selects; reset masks every strobe.
  always_comb begin
    pc_write  = 1'b0;
    pc_sel    = PC_SEL_INC;
    mar_write = 1'b0;
    mar_sel   = MAR_SEL_PC;
    mbr_write = 1'b0;
    ir_write  = 1'b0;
    acc_write = 1'b0;
    acc_sel   = ACC_SEL_ALU;
    mem_write = 1'b0;
    alu_op    = ALU_ADD;
    unique case (st)
      S_F_MAR: mar_write = 1'b1;
      S_F_IR: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        unique case (op)
          OP_SHL: begin
            acc_write = 1'b1;
            alu_op    = ALU_SHL;
          end
          OP_SHR: begin
            acc_write = 1'b1;
            alu_op    = ALU_SHR;
          end
          OP_JUMP: begin
            pc_write = 1'b1;
            pc_sel   = PC_SEL_IR;
          end
          OP_SKIPZ, OP_SKIPNEG: pc_write = skip;
          default: ;
        endcase
      end
      S_E_MAR: begin
        mar_write = 1'b1;
        mar_sel   = MAR_SEL_IR;
      end
      S_E_MBR: mbr_write = 1'b1;
      S_E_EXEC: begin
        unique case (op)
          OP_STORE: mem_write = 1'b1;
          OP_LOAD: begin
            acc_write = 1'b1;
            acc_sel   = ACC_SEL_MBR;
          end
          OP_ADD: begin
            acc_write = 1'b1;
            alu_op    = ALU_ADD;
          end
          OP_SUB: begin
            acc_write = 1'b1;
            alu_op    = ALU_SUB;
          end
          OP_AND: begin
            acc_write = 1'b1;
            alu_op    = ALU_AND;
          end
          OP_OR: begin
            acc_write = 1'b1;
            alu_op    = ALU_OR;
          end
          OP_XOR: begin
            acc_write = 1'b1;
            alu_op    = ALU_XOR;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      mar_write = 1'b0;
      mbr_write = 1'b0;
      ir_write  = 1'b0;
      acc_write = 1'b0;
      mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_accumulator_control_unit.sv
// Directed bench for accumulator_control_unit.
// Two instances: memory latency 1 and memory latency 3.
module tb_accumulator_control_unit;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset1, start1;
  logic [15:0] ir1, acc1;
  logic        pcw1, pcs1, marw1, mars1, mbrw1, irw1;
  logic        accw1, accs1, memw1, halted1, ill1;
  logic [3:0]  alu1, st1;
  logic [15:0] ret1;

  logic        reset3, start3;
  logic [15:0] ir3, acc3;
  logic        pcw3, pcs3, marw3, mars3, mbrw3, irw3;
  logic        accw3, accs3, memw3, halted3, ill3;
  logic [3:0]  alu3, st3;
  logic [15:0] ret3;

  accumulator_control_unit #(
    .DATA_W(16), .ADDR_W(12), .MEM_LATENCY(1)
  ) u1 (
    .clk(clk), .reset(reset1), .start(start1),
    .ir(ir1), .acc(acc1),
    .pc_write(pcw1), .pc_sel(pcs1),
    .mar_write(marw1), .mar_sel(mars1),
    .mbr_write(mbrw1), .ir_write(irw1),
    .acc_write(accw1), .acc_sel(accs1),
    .mem_write(memw1), .alu_op(alu1),
    .halted(halted1), .illegal(ill1),
    .state(st1), .instr_retired(ret1)
  );

  accumulator_control_unit #(
    .DATA_W(16), .ADDR_W(12), .MEM_LATENCY(3)
  ) u3 (
    .clk(clk), .reset(reset3), .start(start3),
    .ir(ir3), .acc(acc3),
    .pc_write(pcw3), .pc_sel(pcs3),
    .mar_write(marw3), .mar_sel(mars3),
    .mbr_write(mbrw3), .ir_write(irw3),
    .acc_write(accw3), .acc_sel(accs3),
    .mem_write(memw3), .alu_op(alu3),
    .halted(halted3), .illegal(ill3),
    .state(st3), .instr_retired(ret3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] strobes1();
    return {pcw1, marw1, mbrw1, irw1, accw1, memw1};
  endfunction

  task automatic rst1();
    reset1 = 1'b1;
    start1 = 1'b0;
    step();
    step();
    reset1 = 1'b0;
  endtask

  task automatic go1();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
  endtask

  typedef struct {
    int         cyc;
    int         accw;
    int         memw;
    int         fwait;
    int         ewait;
    logic [3:0] accw_st;
    logic [3:0] accw_alu;
    logic       accw_sel;
    logic [3:0] memw_st;
  } meas_t;

  // Runs one instruction from F_MAR back to F_MAR or HALT.
  task automatic measure(input bit d3, output meas_t m);
    logic [3:0] s;
    m = '{default: 0};
    for (int i = 0; i < 64; i++) begin
      s = d3 ? st3 : st1;
      if (i > 0 && (s == 4'd1 || s == 4'd9))
        break;
      m.cyc++;
      if (s == 4'd2) m.fwait++;
      if (s == 4'd6) m.ewait++;
      if (d3 ? accw3 : accw1) begin
        m.accw++;
        m.accw_st  = s;
        m.accw_alu = d3 ? alu3 : alu1;
        m.accw_sel = d3 ? accs3 : accs1;
      end
      if (d3 ? memw3 : memw1) begin
        m.memw++;
        m.memw_st = s;
      end
      step();
    end
  endtask

  typedef struct {
    logic [15:0] ir;
    logic [15:0] acc;
    logic        pcw;
    logic        pcs;
    logic        accw;
    logic [3:0]  alu;
    logic [3:0]  nxt;
    logic [15:0] ret;
    logic        ill;
  } vec_t;

  vec_t vt[13];

  logic [3:0] lstate[8];
  logic [5:0] lstrb[8];

  meas_t m;

  initial begin
    vt[0]  = '{16'h0000, 16'h0000, 0, 0, 0, 4'h0, 4'd1, 16'd1, 0};
    vt[1]  = '{16'h1005, 16'h0000, 0, 0, 0, 4'h0, 4'd5, 16'd0, 0};
    vt[2]  = '{16'h2009, 16'h0000, 0, 0, 0, 4'h0, 4'd5, 16'd0, 0};
    vt[3]  = '{16'h8000, 16'h0000, 0, 0, 1, 4'h4, 4'd1, 16'd1, 0};
    vt[4]  = '{16'h9000, 16'h0000, 0, 0, 1, 4'h5, 4'd1, 16'd1, 0};
    vt[5]  = '{16'hA123, 16'h0000, 1, 1, 0, 4'h0, 4'd1, 16'd1, 0};
    vt[6]  = '{16'hB000, 16'h0000, 1, 0, 0, 4'h0, 4'd1, 16'd1, 0};
    vt[7]  = '{16'hB000, 16'h0001, 0, 0, 0, 4'h0, 4'd1, 16'd1, 0};
    vt[8]  = '{16'hC000, 16'h8000, 1, 0, 0, 4'h0, 4'd1, 16'd1, 0};
    vt[9]  = '{16'hC000, 16'h7FFF, 0, 0, 0, 4'h0, 4'd1, 16'd1, 0};
    vt[10] = '{16'hF000, 16'h0000, 0, 0, 0, 4'h0, 4'd9, 16'd1, 0};
    vt[11] = '{16'hD000, 16'h0000, 0, 0, 0, 4'h0, 4'd9, 16'd0, 1};
    vt[12] = '{16'hE000, 16'h0000, 0, 0, 0, 4'h0, 4'd9, 16'd0, 1};

    lstate = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    lstrb  = '{6'b010000, 6'b000000, 6'b100100, 6'b000000,
               6'b010000, 6'b000000, 6'b001000, 6'b000010};

    reset1 = 1'b1; start1 = 1'b0; ir1 = '0; acc1 = '0;
    reset3 = 1'b1; start3 = 1'b0; ir3 = '0; acc3 = '0;
    step();
    step();

    chk("rst_state", st1, 4'd0);
    chk("rst_strobes", strobes1(), 6'd0);
    chk("rst_halted", halted1, 1'b0);
    chk("rst_illegal", ill1, 1'b0);
    chk("rst_retired", ret1, 16'd0);
    reset1 = 1'b0;
    step();
    chk("idle_hold", st1, 4'd0);

    // LOAD 5, cycle by cycle.
    ir1 = 16'h1005;
    go1();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("load_st%0d", i), st1, lstate[i]);
      chk($sformatf("load_strb%0d", i), strobes1(), lstrb[i]);
      if (i == 0) chk("load_marsel_f", mars1, 1'b0);
      if (i == 2) chk("load_pcsel_f", pcs1, 1'b0);
      if (i == 4) chk("load_marsel_e", mars1, 1'b1);
      if (i == 7) chk("load_accsel", accs1, 1'b1);
      step();
    end
    chk("load_back", st1, 4'd1);
    chk("load_ret", ret1, 16'd1);

    // ADD: single ALU write in E_EXEC, 8 cycles.
    rst1();
    ir1 = 16'h3007;
    go1();
    measure(1'b0, m);
    chk("add_cyc", m.cyc, 8);
    chk("add_accw", m.accw, 1);
    chk("add_accw_st", m.accw_st, 4'd8);
    chk("add_alu", m.accw_alu, 4'b0000);
    chk("add_accsel", m.accw_sel, 1'b0);
    chk("add_ret", ret1, 16'd1);

    // Other ALU ops in E_EXEC.
    for (int k = 0; k < 4; k++) begin
      logic [3:0] ea;
      ea = (k == 0) ? 4'b0001 : (k == 1) ? 4'b1000 :
           (k == 2) ? 4'b1001 : 4'b1010;
      rst1();
      ir1 = {4'(4 + k), 12'h010};
      go1();
      measure(1'b0, m);
      chk($sformatf("alu_op_%0d", k + 4), m.accw_alu, ea);
    end

    // STORE: one mem_write in E_EXEC, 6 cycles.
    rst1();
    ir1 = 16'h2009;
    go1();
    measure(1'b0, m);
    chk("store_cyc", m.cyc, 6);
    chk("store_memw", m.memw, 1);
    chk("store_memw_st", m.memw_st, 4'd8);
    chk("store_accw", m.accw, 0);
    chk("store_ret", ret1, 16'd1);

    // DECODE table.
    foreach (vt[j]) begin
      rst1();
      ir1  = vt[j].ir;
      acc1 = vt[j].acc;
      go1();
      for (int w = 0; w < 10 && st1 != 4'd4; w++)
        step();
      chk($sformatf("v%0d_decode", j), st1, 4'd4);
      chk($sformatf("v%0d_pcw", j), pcw1, vt[j].pcw);
      if (vt[j].pcw)
        chk($sformatf("v%0d_pcs", j), pcs1, vt[j].pcs);
      chk($sformatf("v%0d_accw", j), accw1, vt[j].accw);
      if (vt[j].accw) begin
        chk($sformatf("v%0d_alu", j), alu1, vt[j].alu);
        chk($sformatf("v%0d_accs", j), accs1, 1'b0);
      end
      chk($sformatf("v%0d_other", j),
          {marw1, mbrw1, irw1, memw1}, 4'd0);
      step();
      chk($sformatf("v%0d_next", j), st1, vt[j].nxt);
      chk($sformatf("v%0d_ret", j), ret1, vt[j].ret);
      chk($sformatf("v%0d_ill", j), ill1, vt[j].ill);
      chk($sformatf("v%0d_halted", j), halted1,
          vt[j].nxt == 4'd9);
    end

    // Illegal opcode leaves HALT only through reset.
    rst1();
    ir1 = 16'hD000;
    go1();
    for (int w = 0; w < 10 && st1 != 4'd9; w++)
      step();
    start1 = 1'b1;
    step();
    step();
    start1 = 1'b0;
    step();
    chk("ill_stay", st1, 4'd9);
    chk("ill_halted", halted1, 1'b1);
    chk("ill_flag", ill1, 1'b1);
    chk("ill_ret", ret1, 16'd0);
    chk("ill_strobes", strobes1(), 6'd0);

    // Reset during E_EXEC of STORE.
    rst1();
    ir1 = 16'h0000;
    go1();
    measure(1'b0, m);
    ir1 = 16'h2009;
    for (int w = 0; w < 20 && st1 != 4'd8; w++)
      step();
    chk("mid_exec", st1, 4'd8);
    chk("mid_memw_pre", memw1, 1'b1);
    reset1 = 1'b1;
    #1;
    chk("mid_memw_rst", memw1, 1'b0);
    chk("mid_strobes_rst", strobes1(), 6'd0);
    step();
    reset1 = 1'b0;
    chk("mid_state", st1, 4'd0);
    chk("mid_strobes", strobes1(), 6'd0);
    chk("mid_ret", ret1, 16'd0);
    chk("mid_ill", ill1, 1'b0);
    chk("mid_halted", halted1, 1'b0);

    // Retire counter wrap, preloaded while idle.
    rst1();
    force u1.instr_retired = 16'hFFFF;
    #1;
    release u1.instr_retired;
    #1;
    chk("wrap_pre", ret1, 16'hFFFF);
    ir1 = 16'h0000;
    go1();
    measure(1'b0, m);
    chk("nop_cyc", m.cyc, 4);
    chk("wrap_ret", ret1, 16'h0000);
    measure(1'b0, m);
    chk("wrap_ret2", ret1, 16'h0001);

    // Latency 3: LOAD takes 12 cycles, each wait 3.
    reset3 = 1'b0;
    ir3 = 16'h1005;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    chk("l3_fmar", st3, 4'd1);
    measure(1'b1, m);
    chk("l3_load_cyc", m.cyc, 12);
    chk("l3_fwait", m.fwait, 3);
    chk("l3_ewait", m.ewait, 3);
    chk("l3_accsel", m.accw_sel, 1'b1);
    chk("l3_ret", ret3, 16'd1);
    ir3 = 16'h2001;
    measure(1'b1, m);
    chk("l3_store_cyc", m.cyc, 8);
    ir3 = 16'h8000;
    measure(1'b1, m);
    chk("l3_shl_cyc", m.cyc, 6);
    chk("l3_ret3", ret3, 16'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
